dea_stream: RTL and testbench
=============================

# dea_stream

Parametrised successor to the 8-bit DEA XOR cipher. Holds a key table of up to KEYS_MAX keys of WIDTH bits, loaded serially through the data port while `kset` is high. When `kset` is low it encrypts/decrypts (XOR is symmetric) a valid/ready data stream, cycling through the loaded keys. Sits between the byte-stream source and sink in the encryption datapath, with a registered, back-pressurable output.

## Interface
- WIDTH, 8: data and key width in bits (≥2).
- KEYS_MAX, 4: key table depth (≥1). Index widths are $clog2-derived; num_keys is $clog2(KEYS_MAX+1) bits.
- dclk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- kset  in  1  1 = key-load mode, 0 = data mode.
- din  in  WIDTH  key word (kset=1) or plaintext/ciphertext (kset=0).
- in_valid  in  1  din qualifier.
- in_ready  out  1  combinational: 1 when kset=1, else (!dout_valid || dout_ready).
- dout  out  WIDTH  registered result.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  sink accept.
- num_keys  out  $clog2(KEYS_MAX+1)  keys currently loaded.
- key_ovf  out  1  sticky: key write attempted while table full.
- no_key  out  1  sticky: data accepted with num_keys=0.

## Operation
- Reset values: dout=0, dout_valid=0, num_keys=0, key_idx=0, key_ovf=0, no_key=0. Key table contents are don't-care.
- Key write: kset=1 && in_valid.
  - If num_keys<KEYS_MAX: keys[num_keys]<=din, num_keys++.
  - Else: the write is dropped and key_ovf<=1.
  - Every key write sets key_idx<=0 and pass<=0.
- Reload:
  - The first key write following a data-mode transfer (kset was 0 and at least one word was accepted since the last key write) restarts the table.
  - keys[0]<=din, num_keys<=1. key_ovf and no_key are cleared.
- Data transfer: kset=0 && in_valid && in_ready.
  - Result: dout<=din ^ eff_key(key_idx), dout_valid<=1.
  - Index update: key_idx<=(key_idx==num_keys-1) ? 0 : key_idx+1. The wrap point is the loaded count, not KEYS_MAX.
  - If num_keys=0: dout<=din (bypass), no_key<=1, key_idx unchanged.
- Output register: if dout_valid && dout_ready and there is no new transfer, dout_valid<=0 and dout holds its value.
- Mode switch while dout_valid=1: the held dout is unaffected. Key writes never stall and never disturb the output register.
- Simultaneous reset with any other event: reset wins.

## Timing
- Latency: a word accepted at edge N appears on dout/dout_valid after edge N.
- Throughput: 1 word/cycle while dout_ready=1.
- A key written at edge N is usable by a data word accepted at edge N+1.
- in_ready depends combinationally on kset, dout_valid and dout_ready. It has no path from din or in_valid.

## Configuration
- DEA_ROTATE_EN, defined:
  - A pass counter (width $clog2(WIDTH)) increments modulo WIDTH each time key_idx wraps to 0. It only wraps when num_keys>0.
  - eff_key = keys[key_idx] rotated left by pass bits.
  - The counter is cleared by reset and by any key write.
- DEA_ROTATE_EN, undefined: eff_key = keys[key_idx]. No pass counter is built.

## Test plan
- WIDTH=8, KEYS_MAX=4, dout_ready=1. Load AA,BB,CC,DD; send 12,34,56,78,9A -> dout B8,8F,9A,A5,30; num_keys=4.
- Reset, then load 55,66; send 11,22,33 -> dout 44,44,66, showing wrap at num_keys=2. Then reload with kset=1, din=0F; send F0 -> FF, num_keys=1.
- Load 01,02,03,04,05 -> num_keys=4, key_ovf=1. Send 00×5 -> 01,02,03,04,01.
- Backpressure:
  - After a key load, hold dout_ready=0 and keep in_valid=1.
  - Expected: the first result is held, in_ready=0, and no key_idx advance.
  - Release dout_ready -> next word out on the following cycle, with no loss or duplication.
- No keys after reset: send 3C -> dout 3C, no_key=1. Reset mid-stream -> dout_valid=0, num_keys=0 on the next cycle.
- Load key 81 only; send 00,00,00. With DEA_ROTATE_EN -> 81,03,06. Without DEA_ROTATE_EN -> 81,81,81.

Source files
------------

// File: rtl/dea_stream.sv
// dea_stream: streaming XOR cipher with a serially loaded key table.
//
// While kset is high, words on din are appended to the key table. While kset
// is low, accepted words are XORed with the current key, and the key index
// steps through the loaded keys. The output register can be back-pressured.
// Because XOR is symmetric, the same block both encrypts and decrypts.
//
// Optional feature macro: DEA_ROTATE_EN
//   defined   - a pass counter rotates each key left by one more bit after
//               every full sweep of the loaded keys.
//   undefined - each key is used as stored, and no pass counter is built.
module dea_stream #(
  parameter int WIDTH    = 8,
  parameter int KEYS_MAX = 4
) (
  input  logic                          dclk,
  input  logic                          reset,
  input  logic                          kset,
  input  logic [WIDTH-1:0]              din,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(KEYS_MAX+1)-1:0] num_keys,
  output logic                          key_ovf,
  output logic                          no_key
);

  // Count width holds 0..KEYS_MAX, and the index width addresses 0..KEYS_MAX-1.
  localparam int NW = $clog2(KEYS_MAX + 1);
  localparam int IW = (KEYS_MAX > 1) ? $clog2(KEYS_MAX) : 1;

  // Key storage. It needs no reset, because the entries past num_keys are never used.
  logic [WIDTH-1:0] keys [KEYS_MAX];

  logic [IW-1:0]    key_idx;
  // This flag is set once any data word has been accepted since the last key write.
  // The next key write then restarts the table instead of appending to it.
  logic             data_seen;

  logic             key_wr;
  logic             xfer;
  logic             reload;
  logic             table_full;
  logic             idx_last;
  logic             key_store;
  logic [IW-1:0]    wr_addr;
  logic [WIDTH-1:0] key_word;
  logic [WIDTH-1:0] eff_key;

  // Key writes never stall. Data words are accepted whenever the output slot is free or is draining.
  assign in_ready   = kset | ~dout_valid | dout_ready;

  assign key_wr     = kset & in_valid;
  assign xfer       = ~kset & in_valid & in_ready;
  assign reload     = key_wr & data_seen;
  assign table_full = (num_keys == NW'(KEYS_MAX));
  assign key_store  = key_wr & (reload | ~table_full);
  assign wr_addr    = reload ? '0 : num_keys[IW-1:0];

  // The index wraps at the number of loaded keys, not at the table depth.
  assign idx_last   = (NW'(key_idx) == (num_keys - NW'(1)));
  assign key_word   = keys[key_idx];

`ifdef DEA_ROTATE_EN
  localparam int PW = $clog2(WIDTH);

  logic [PW-1:0]      pass;
  logic [2*WIDTH-1:0] rot_pair;

  // Left rotation: shift a doubled copy of the key and keep the upper half.
  assign rot_pair = {key_word, key_word} << pass;
  assign eff_key  = rot_pair[2*WIDTH-1:WIDTH];

  // The pass count advances modulo WIDTH each time the key index wraps to 0. Any key write restarts it.
  always_ff @(posedge dclk) begin
    if (reset) begin
      pass <= '0;
    end else if (key_wr) begin
      pass <= '0;
    end else if (xfer && (num_keys != '0) && idx_last) begin
      pass <= (pass == PW'(WIDTH - 1)) ? '0 : pass + PW'(1);
    end
  end
`else
  assign eff_key = key_word;
`endif

  // Key table write port: it appends at num_keys, or writes entry 0 on a reload.
  always_ff @(posedge dclk) begin
    if (key_store) begin
      keys[wr_addr] <= din;
    end
  end

  // Control state: key count, key index, reload tracking and the sticky flags.
  always_ff @(posedge dclk) begin
    if (reset) begin
      num_keys  <= '0;
      key_idx   <= '0;
      key_ovf   <= 1'b0;
      no_key    <= 1'b0;
      data_seen <= 1'b0;
    end else if (key_wr) begin
      key_idx   <= '0;
      data_seen <= 1'b0;
      if (reload) begin
        num_keys <= NW'(1);
        key_ovf  <= 1'b0;
        no_key   <= 1'b0;
      end else if (!table_full) begin
        num_keys <= num_keys + NW'(1);
      end else begin
        key_ovf <= 1'b1;
      end
    end else if (xfer) begin
      data_seen <= 1'b1;
      if (num_keys == '0) begin
        no_key <= 1'b1;
      end else begin
        key_idx <= idx_last ? '0 : key_idx + IW'(1);
      end
    end
  end

  // Output register: it loads on a transfer and drains on a sink accept. Otherwise it holds.
  always_ff @(posedge dclk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (xfer) begin
      dout       <= (num_keys == '0) ? din : (din ^ eff_key);
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dea_stream.sv
// tb_dea_stream: directed scenarios followed by a random phase.
// Both phases are checked against a word-count reference model.
module tb_dea_stream;

  localparam int WIDTH    = 8;
  localparam int KEYS_MAX = 4;

  logic       dclk = 1'b0;
  logic       reset = 1'b1;
  logic       kset = 1'b0;
  logic [7:0] din = 8'h00;
  logic       in_valid = 1'b0;
  logic       dout_ready = 1'b1;
  logic       in_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] num_keys;
  logic       key_ovf;
  logic       no_key;

  int checks = 0;
  int errors = 0;

  // Reference model. The key position and the rotation both follow from
  // m_cnt, the number of words accepted since the last key write.
  logic [7:0] m_keys [KEYS_MAX];
  int         m_n = 0;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       m_nokey = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_dout = 8'h00;

  dea_stream #(.WIDTH(WIDTH), .KEYS_MAX(KEYS_MAX)) dut (
    .dclk       (dclk),
    .reset      (reset),
    .kset       (kset),
    .din        (din),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .num_keys   (num_keys),
    .key_ovf    (key_ovf),
    .no_key     (no_key)
  );

  always #5 dclk = ~dclk;

  function automatic logic [7:0] m_eff(input int cnt);
    logic [15:0] pair;
    int p;
    p = 0;
`ifdef DEA_ROTATE_EN
    p = (cnt / m_n) % WIDTH;
`endif
    pair = {m_keys[cnt % m_n], m_keys[cnt % m_n]} << p;
    return pair[15:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the inputs, check in_ready, advance the model, then check all outputs.
  task automatic step(input logic k, input logic [7:0] d, input logic v,
                      input logic r, input logic rst);
    logic exp_ready;
    logic acc;
    @(negedge dclk);
    kset = k; din = d; in_valid = v; dout_ready = r; reset = rst;
    #1;
    exp_ready = k | ~m_valid | r;
    if (!rst) check("in_ready", in_ready, exp_ready);
    acc = ~k & v & exp_ready;
    @(posedge dclk);
    if (rst) begin
      m_n = 0; m_cnt = 0; m_ovf = 0; m_nokey = 0; m_valid = 0; m_dout = 8'h00;
    end else if (k) begin
      if (v) begin
        if (m_cnt > 0) begin
          m_keys[0] = d; m_n = 1; m_ovf = 0; m_nokey = 0;
        end else if (m_n < KEYS_MAX) begin
          m_keys[m_n] = d; m_n++;
        end else begin
          m_ovf = 1;
        end
        m_cnt = 0;
      end
      if (m_valid && r) m_valid = 0;
    end else if (acc) begin
      if (m_n == 0) begin
        m_dout = d; m_nokey = 1;
      end else begin
        m_dout = d ^ m_eff(m_cnt);
      end
      m_valid = 1;
      m_cnt++;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    #1;
    $display("t=%0t rst=%0b kset=%0b din=%02h vld=%0b rdy=%0b -> dout=%02h dv=%0b nk=%0d ovf=%0b nokey=%0b",
             $time, rst, k, d, v, r, dout, dout_valid, num_keys, key_ovf, no_key);
    check("dout", dout, m_dout);
    check("dout_valid", dout_valid, m_valid);
    check("num_keys", num_keys, m_n);
    check("key_ovf", key_ovf, m_ovf);
    check("no_key", no_key, m_nokey);
  endtask

  initial begin
    // Reset state
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 1, 1);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_nkeys", num_keys, 3'd0);

    // Scenario 1: four keys, five words
    step(1, 8'hAA, 1, 1, 0); step(1, 8'hBB, 1, 1, 0);
    step(1, 8'hCC, 1, 1, 0); step(1, 8'hDD, 1, 1, 0);
    step(0, 8'h12, 1, 1, 0); check("s1_w0", dout, 8'hB8);
    step(0, 8'h34, 1, 1, 0); check("s1_w1", dout, 8'h8F);
    step(0, 8'h56, 1, 1, 0); check("s1_w2", dout, 8'h9A);
    step(0, 8'h78, 1, 1, 0); check("s1_w3", dout, 8'hA5);
    step(0, 8'h9A, 1, 1, 0);
`ifdef DEA_ROTATE_EN
    check("s1_w4", dout, 8'hCF);
`else
    check("s1_w4", dout, 8'h30);
`endif
    check("s1_nkeys", num_keys, 3'd4);

    // Scenario 2: index wraps at two keys, then a reload
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'h55, 1, 1, 0); step(1, 8'h66, 1, 1, 0);
    step(0, 8'h11, 1, 1, 0); check("s2_w0", dout, 8'h44);
    step(0, 8'h22, 1, 1, 0); check("s2_w1", dout, 8'h44);
    step(0, 8'h33, 1, 1, 0);
`ifdef DEA_ROTATE_EN
    check("s2_w2", dout, 8'h99);
`else
    check("s2_w2", dout, 8'h66);
`endif
    step(1, 8'h0F, 1, 1, 0);
    step(0, 8'hF0, 1, 1, 0); check("s2_reload", dout, 8'hFF);
    check("s2_nkeys", num_keys, 3'd1);

    // Scenario 3: overflow (this sequence also begins with a reload)
    step(1, 8'h01, 1, 1, 0); step(1, 8'h02, 1, 1, 0); step(1, 8'h03, 1, 1, 0);
    step(1, 8'h04, 1, 1, 0); step(1, 8'h05, 1, 1, 0);
    check("s3_nkeys", num_keys, 3'd4);
    check("s3_ovf", key_ovf, 1'b1);
    step(0, 8'h00, 1, 1, 0); check("s3_w0", dout, 8'h01);
    step(0, 8'h00, 1, 1, 0); check("s3_w1", dout, 8'h02);
    step(0, 8'h00, 1, 1, 0); check("s3_w2", dout, 8'h03);
    step(0, 8'h00, 1, 1, 0); check("s3_w3", dout, 8'h04);
    step(0, 8'h00, 1, 1, 0);
`ifdef DEA_ROTATE_EN
    check("s3_w4", dout, 8'h02);
`else
    check("s3_w4", dout, 8'h01);
`endif

    // Scenario 4: backpressure
    step(1, 8'h5A, 1, 1, 0); step(1, 8'h3C, 1, 1, 0);
    step(0, 8'hA1, 1, 0, 0); check("bp_first", dout, 8'hFB);
    step(0, 8'hB2, 1, 0, 0); check("bp_hold0", dout, 8'hFB);
    check("bp_ready", in_ready, 1'b0);
    step(0, 8'hB2, 1, 0, 0); check("bp_hold1", dout, 8'hFB);
    step(0, 8'hB2, 1, 1, 0); check("bp_next", dout, 8'h8E);
    step(0, 8'hC3, 1, 1, 0);
    step(0, 8'h00, 0, 1, 0); check("bp_drain", dout_valid, 1'b0);

    // Scenario 5: no keys loaded, then reset in the middle of a stream
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h3C, 1, 1, 0); check("nk_bypass", dout, 8'h3C);
    check("nk_flag", no_key, 1'b1);
    step(0, 8'h45, 1, 1, 0);
    step(0, 8'h46, 1, 1, 1);
    check("mid_rst_valid", dout_valid, 1'b0);
    check("mid_rst_nkeys", num_keys, 3'd0);

    // Scenario 6: a single key with rotation
    step(1, 8'h81, 1, 1, 0);
    step(0, 8'h00, 1, 1, 0); check("rot_w0", dout, 8'h81);
    step(0, 8'h00, 1, 1, 0);
`ifdef DEA_ROTATE_EN
    check("rot_w1", dout, 8'h03);
`else
    check("rot_w1", dout, 8'h81);
`endif
    step(0, 8'h00, 1, 1, 0);
`ifdef DEA_ROTATE_EN
    check("rot_w2", dout, 8'h06);
`else
    check("rot_w2", dout, 8'h81);
`endif

    // Random phase
    for (int i = 0; i < 400; i++) begin
      logic       rk, rv, rr, rrst;
      logic [7:0] rd;
      rk   = ($urandom_range(0, 4) == 0);
      rd   = 8'($urandom);
      rv   = ($urandom_range(0, 3) != 0);
      rr   = ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 99) == 0);
      step(rk, rd, rv, rr, rrst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
